// File: rtl/bf_sequencer.sv
// bf_sequencer: instruction sequencer for the four dekatron counter channels (IP, AP, Loop, Data).
// Fetches the opcode at IP, pulses Request/Dec at the proper counter and resolves brackets by IP scanning.
module bf_sequencer #(
    parameter int OP_W = 4
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic            Stop,
    input  logic [OP_W-1:0] Instr,
    input  logic            ReadyIP,
    input  logic            ReadyAP,
    input  logic            ReadyLoop,
    input  logic            ReadyData,
    input  logic            ZeroLoop,
    input  logic            ZeroData,
    output logic            RequestIP,
    output logic            RequestAP,
    output logic            RequestLoop,
    output logic            RequestData,
    output logic            DecIP,
    output logic            DecAP,
    output logic            DecLoop,
    output logic            DecData,
    output logic            Busy,
    output logic            Halted,
    output logic [2:0]      DbgState
);

    // Handshake: Request is a one-cycle strobe issued only while the target Ready=1.
    // Ready is ignored during the strobe cycle; the operation is done when Ready is next seen high.

    localparam logic [OP_W-1:0] OP_INC   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_DEC   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_RIGHT = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LEFT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OPEN  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CLOSE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_WAIT_OP = 3'd3,
        S_IP_STEP = 3'd4,
        S_WAIT_IP = 3'd5,
        S_HALTED  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        TGT_AP   = 2'd0,
        TGT_LOOP = 2'd1,
        TGT_DATA = 2'd2
    } target_t;

    state_t          state;
    target_t         tgt;
    logic [OP_W-1:0] op;
    logic            dir;
    logic            scan;
    logic            stopPend;

    logic readyTgt;
    logic opStrobe;
    logic scanNest;
    logic scanMatch;

    assign DbgState = state;
    assign opStrobe = RequestAP | RequestLoop | RequestData;

    always_comb begin
        readyTgt = ReadyData;
        case (tgt)
            TGT_AP:   readyTgt = ReadyAP;
            TGT_LOOP: readyTgt = ReadyLoop;
            default:  readyTgt = ReadyData;
        endcase
    end

    // While scanning, a bracket facing the scan direction nests deeper; the opposite one closes a level.
    always_comb begin
        scanNest  = scan && ((!dir && op == OP_OPEN)  || (dir && op == OP_CLOSE));
        scanMatch = scan && ((!dir && op == OP_CLOSE) || (dir && op == OP_OPEN));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            tgt         <= TGT_DATA;
            op          <= '0;
            dir         <= 1'b0;
            scan        <= 1'b0;
            stopPend    <= 1'b0;
            RequestIP   <= 1'b0;
            RequestAP   <= 1'b0;
            RequestLoop <= 1'b0;
            RequestData <= 1'b0;
            DecIP       <= 1'b0;
            DecAP       <= 1'b0;
            DecLoop     <= 1'b0;
            DecData     <= 1'b0;
            Busy        <= 1'b0;
            Halted      <= 1'b0;
        end else begin
            RequestIP   <= 1'b0;
            RequestAP   <= 1'b0;
            RequestLoop <= 1'b0;
            RequestData <= 1'b0;
            DecIP       <= 1'b0;
            DecAP       <= 1'b0;
            DecLoop     <= 1'b0;
            DecData     <= 1'b0;

            if (Stop && state != S_IDLE && state != S_HALTED) begin
                stopPend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_FETCH;
                        Busy  <= 1'b1;
                    end
                end

                S_FETCH: begin
                    op    <= Instr;
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    if (!scan) begin
                        case (op)
                            OP_INC, OP_DEC: begin
                                if (ReadyData) begin
                                    RequestData <= 1'b1;
                                    DecData     <= (op == OP_DEC);
                                    tgt         <= TGT_DATA;
                                    state       <= S_WAIT_OP;
                                end
                            end
                            OP_RIGHT, OP_LEFT: begin
                                if (ReadyAP) begin
                                    RequestAP <= 1'b1;
                                    DecAP     <= (op == OP_LEFT);
                                    tgt       <= TGT_AP;
                                    state     <= S_WAIT_OP;
                                end
                            end
                            OP_OPEN: begin
                                if (ZeroData) begin
                                    scan <= 1'b1;
                                    dir  <= 1'b0;
                                end
                                state <= S_IP_STEP;
                            end
                            OP_CLOSE: begin
                                if (!ZeroData) begin
                                    scan <= 1'b1;
                                    dir  <= 1'b1;
                                end
                                state <= S_IP_STEP;
                            end
                            OP_HALT: begin
                                state  <= S_HALTED;
                                Busy   <= 1'b0;
                                Halted <= 1'b1;
                            end
                            default: state <= S_IP_STEP;
                        endcase
                    end else if (scanNest || (scanMatch && !ZeroLoop)) begin
                        if (ReadyLoop) begin
                            RequestLoop <= 1'b1;
                            DecLoop     <= !scanNest;
                            tgt         <= TGT_LOOP;
                            state       <= S_WAIT_OP;
                        end
                    end else if (scanMatch) begin
                        // Matching bracket at depth zero: leave scan and resume forward execution.
                        scan  <= 1'b0;
                        dir   <= 1'b0;
                        state <= S_IP_STEP;
                    end else begin
                        state <= S_IP_STEP;
                    end
                end

                S_WAIT_OP: begin
                    if (!opStrobe && readyTgt) begin
                        state <= S_IP_STEP;
                    end
                end

                S_IP_STEP: begin
                    if (ReadyIP) begin
                        RequestIP <= 1'b1;
                        DecIP     <= dir;
                        state     <= S_WAIT_IP;
                    end
                end

                S_WAIT_IP: begin
                    if (!RequestIP && ReadyIP) begin
                        if (stopPend) begin
                            state    <= S_IDLE;
                            Busy     <= 1'b0;
                            stopPend <= 1'b0;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end

                S_HALTED: state <= S_HALTED;

                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
